// File: rtl/hpm_sample_ctrl.sv
// hpm_sample_ctrl
//
// This block owns the single CSR access port of the HPM counter bank.
// The core CSR unit always has priority and is never stalled.
// A periodic sampler reads a contiguous window of mhpmcounter3..31 each
// period and streams every value to the trace/debug sink.
//
// Sample stream handshake (smp_*): a transfer happens on a rising clock edge
// where smp_valid_o && smp_ready_i are both high. Once smp_valid_o is raised,
// smp_idx_o / smp_data_o / smp_last_o stay stable and valid stays high until
// that transfer happens. This holds even if cfg_en_i falls. Only reset can
// withdraw valid.
//
// state_o exposes the FSM state (0=IDLE, 1=RD, 2=SEND) for debug.
module hpm_sample_ctrl #(
  parameter int unsigned PERIOD_W      = 32,
  parameter int unsigned DROP_W        = 16,
  parameter int unsigned CSR_ADDR_SIZE = 12,
  parameter logic [CSR_ADDR_SIZE-1:0] CSR_MHPM_COUNTER_3 = 12'hB03
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [CSR_ADDR_SIZE-1:0] core_addr_i,
  input  logic [63:0]              core_wdata_i,
  output logic [63:0]              core_rdata_o,
  output logic [CSR_ADDR_SIZE-1:0] hpm_addr_o,
  output logic                     hpm_we_o,
  output logic [63:0]              hpm_wdata_o,
  input  logic [63:0]              hpm_rdata_i,
  input  logic                     cfg_en_i,
  input  logic [PERIOD_W-1:0]      cfg_period_i,
  input  logic [4:0]               cfg_first_i,
  input  logic [4:0]               cfg_num_i,
  output logic                     smp_valid_o,
  input  logic                     smp_ready_i,
  output logic [4:0]               smp_idx_o,
  output logic [63:0]              smp_data_o,
  output logic                     smp_last_o,
  output logic                     busy_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] timer_q;
  logic [PERIOD_W-1:0] period_m1;
  logic                timer_active;
  logic                tick;
  logic                start;
  logic                hs;
  logic                busy;
  logic [5:0]          last_sum;
  logic [4:0]          last_idx_d;
  logic [4:0]          cur_idx_q;
  logic [4:0]          last_idx_q;
  logic [4:0]          smp_idx_q;
  logic [63:0]         smp_data_q;
  logic                smp_last_q;
  logic [DROP_W-1:0]   drop_q;
  logic [CSR_ADDR_SIZE-1:0] rd_addr;

  // The timer runs only while the sampler is enabled with a non-zero period.
  assign timer_active = cfg_en_i && (cfg_period_i != '0);
  assign period_m1    = cfg_period_i - PERIOD_W'(1);
  assign tick         = timer_active && (timer_q == period_m1);

  // The window end uses a 6-bit sum so that first+num-1 cannot wrap before it is clipped to 31.
  assign last_sum   = {1'b0, cfg_first_i} + {1'b0, cfg_num_i} - 6'd1;
  assign last_idx_d = (last_sum > 6'd31) ? 5'd31 : last_sum[4:0];

  // Ticks with an empty window or a first index below 3 are ignored.
  assign start = tick && (cfg_num_i != 5'd0) && (cfg_first_i >= 5'd3);
  assign busy  = (state_q != ST_IDLE);
  assign hs    = (state_q == ST_SEND) && smp_ready_i;

  assign rd_addr = CSR_MHPM_COUNTER_3 + CSR_ADDR_SIZE'(cur_idx_q) - CSR_ADDR_SIZE'(3);

  // Cycle timer. It wraps silently when the period is lowered below its current value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer_q <= '0;
    end else if (!timer_active) begin
      timer_q <= '0;
    end else if (timer_q >= period_m1) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + PERIOD_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The core owns the port in any cycle it requests it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RD;
      end
      ST_RD: begin
        if (!cfg_en_i)       state_d = ST_IDLE;
        else if (!core_req_i) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (hs) state_d = (smp_last_q || !cfg_en_i) ? ST_IDLE : ST_RD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and port-mux logic.
  always_comb begin
    smp_valid_o  = (state_q == ST_SEND);
    busy_o       = busy;
    state_o      = state_q;
    core_rdata_o = core_req_i ? hpm_rdata_i : 64'd0;
    hpm_addr_o   = '0;
    hpm_we_o     = 1'b0;
    hpm_wdata_o  = 64'd0;
    if (core_req_i) begin
      hpm_addr_o  = core_addr_i;
      hpm_we_o    = core_we_i;
      hpm_wdata_o = core_wdata_i;
    end else if (state_q == ST_RD) begin
      hpm_addr_o = rd_addr;
    end
  end

  // Burst window, sample capture and index advance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_idx_q  <= '0;
      last_idx_q <= '0;
      smp_idx_q  <= '0;
      smp_data_q <= '0;
      smp_last_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        cur_idx_q  <= cfg_first_i;
        last_idx_q <= last_idx_d;
      end
      if ((state_q == ST_RD) && cfg_en_i && !core_req_i) begin
        smp_data_q <= hpm_rdata_i;
        smp_idx_q  <= cur_idx_q;
        smp_last_q <= (cur_idx_q == last_idx_q);
      end
      if (hs && !smp_last_q && cfg_en_i) begin
        cur_idx_q <= cur_idx_q + 5'd1;
      end
    end
  end

  // A tick that arrives while a burst is in flight is dropped and counted, saturating.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_q <= '0;
    end else if (tick && busy && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign smp_idx_o  = smp_idx_q;
  assign smp_data_o = smp_data_q;
  assign smp_last_o = smp_last_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_hpm_sample_ctrl.sv
// Bench for hpm_sample_ctrl: the counter bank is modelled as a fixed function of the address.
module tb_hpm_sample_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [11:0] core_addr_i = '0;
  logic [63:0] core_wdata_i = '0;
  logic [63:0] core_rdata_o;
  logic [11:0] hpm_addr_o;
  logic        hpm_we_o;
  logic [63:0] hpm_wdata_o;
  logic [63:0] hpm_rdata_i;
  logic        cfg_en_i = 1'b0;
  logic [31:0] cfg_period_i = '0;
  logic [4:0]  cfg_first_i = '0;
  logic [4:0]  cfg_num_i = '0;
  logic        smp_valid_o;
  logic        smp_ready_i = 1'b0;
  logic [4:0]  smp_idx_o;
  logic [63:0] smp_data_o;
  logic        smp_last_o;
  logic        busy_o;
  logic [15:0] drop_cnt_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_drop = '0;
  logic [69:0] exp_q[$];

  hpm_sample_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
    .hpm_addr_o(hpm_addr_o), .hpm_we_o(hpm_we_o), .hpm_wdata_o(hpm_wdata_o),
    .hpm_rdata_i(hpm_rdata_i),
    .cfg_en_i(cfg_en_i), .cfg_period_i(cfg_period_i), .cfg_first_i(cfg_first_i),
    .cfg_num_i(cfg_num_i),
    .smp_valid_o(smp_valid_o), .smp_ready_i(smp_ready_i), .smp_idx_o(smp_idx_o),
    .smp_data_o(smp_data_o), .smp_last_o(smp_last_o),
    .busy_o(busy_o), .drop_cnt_o(drop_cnt_o), .state_o(state_o)
  );

  // clock / bank model
  always #5 clk_i = ~clk_i;
  assign hpm_rdata_i = {32'hC0FF_EE00, 20'h0, hpm_addr_o};

  // mhpmcounterN lives at 0xB00+N
  function automatic logic [63:0] exp_bank(input logic [4:0] idx);
    logic [11:0] a;
    a = 12'hB00 + {7'd0, idx};
    return {32'hC0FF_EE00, 20'h0, a};
  endfunction

  function automatic void push_exp(input logic [4:0] idx, input logic last);
    exp_q.push_back({idx, last, exp_bank(idx)});
  endfunction

  // scoreboard monitor: pops on every handshake, checks hold while stalled
  logic        prev_pend = 1'b0;
  logic [69:0] prev_val = '0;
  always @(negedge clk_i) begin
    logic [69:0] act, exp;
    act = {smp_idx_o, smp_last_o, smp_data_o};
    if (!rstn_i) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        n_cmp++;
        if (smp_valid_o !== 1'b1 || act !== prev_val) begin
          n_err++;
          $display("FAIL hold: valid=%b sample=%h required valid=1 sample=%h", smp_valid_o, act, prev_val);
        end
      end
      if (smp_valid_o && smp_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_sample: got %h, none required", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL sample: got idx=%0d last=%b data=%h required idx=%0d last=%b data=%h",
                     act[69:65], act[64], act[63:0], exp[69:65], exp[64], exp[63:0]);
          end
        end
        prev_pend = 1'b0;
      end else begin
        prev_pend = smp_valid_o;
        prev_val  = act;
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    idle_cycles(3);
    n_cmp++;
    if ({smp_valid_o, busy_o, smp_idx_o, smp_last_o, smp_data_o, drop_cnt_o, state_o, hpm_addr_o, hpm_we_o, hpm_wdata_o, core_rdata_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b busy=%b idx=%0d data=%h drop=%0d state=%0d addr=%h required all 0",
               smp_valid_o, busy_o, smp_idx_o, smp_data_o, drop_cnt_o, state_o, hpm_addr_o);
    end
    rstn_i = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_core_access();
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 12'hB05;
    @(negedge clk_i);
    n_cmp++;
    if (hpm_addr_o !== 12'hB05 || hpm_we_o !== 1'b0) begin
      n_err++; $display("FAIL core_rd_addr: addr=%h we=%b required B05/0", hpm_addr_o, hpm_we_o);
    end
    n_cmp++;
    if (core_rdata_o !== exp_bank(5'd5)) begin
      n_err++; $display("FAIL core_rdata: got %h required %h", core_rdata_o, exp_bank(5'd5));
    end
    n_cmp++;
    if (smp_valid_o !== 1'b0) begin
      n_err++; $display("FAIL core_no_sample: valid=%b required 0", smp_valid_o);
    end
    @(posedge clk_i); #1;
    core_we_i = 1'b1; core_wdata_i = wd; core_addr_i = 12'hB07;
    @(negedge clk_i);
    n_cmp++;
    if (hpm_we_o !== 1'b1 || hpm_wdata_o !== wd || hpm_addr_o !== 12'hB07) begin
      n_err++; $display("FAIL core_wr: we=%b wdata=%h addr=%h required 1/%h/B07", hpm_we_o, hpm_wdata_o, hpm_addr_o, wd);
    end
    @(posedge clk_i); #1;
    core_req_i = 1'b0; core_we_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (hpm_addr_o !== 12'h0 || hpm_we_o !== 1'b0 || core_rdata_o !== 64'd0) begin
      n_err++; $display("FAIL core_release: addr=%h we=%b rdata=%h required 0", hpm_addr_o, hpm_we_o, core_rdata_o);
    end
  endtask

  // period 10, window 3..5, sink always ready: first valid at cycle 11, then 21, 31
  task automatic test_bursts();
    int found[3];
    int nf;
    nf = 0;
    for (int b = 0; b < 3; b++) begin
      push_exp(5'd3, 1'b0); push_exp(5'd4, 1'b0); push_exp(5'd5, 1'b1);
    end
    for (int c = 0; c <= 37; c++) begin
      @(posedge clk_i); #1;
      cfg_en_i = (c < 37); cfg_period_i = 32'd10; cfg_first_i = 5'd3; cfg_num_i = 5'd3; smp_ready_i = 1'b1;
      @(negedge clk_i);
      if (smp_valid_o && smp_idx_o == 5'd3 && nf < 3) begin found[nf] = c; nf++; end
    end
    for (int b = 0; b < 3; b++) begin
      n_cmp++;
      if (nf <= b || found[b] != 11 + 10 * b) begin
        n_err++; $display("FAIL burst_start%0d: cycle=%0d (seen %0d) required %0d", b, (nf > b) ? found[b] : -1, nf, 11 + 10 * b);
      end
    end
    n_cmp++;
    if (drop_cnt_o !== exp_drop || exp_q.size() != 0) begin
      n_err++; $display("FAIL bursts_end: drop=%0d pending=%0d required drop=%0d pending=0", drop_cnt_o, exp_q.size(), exp_drop);
    end
  endtask

  // core holds the port for 4 cycles while the sampler sits in RD
  task automatic test_core_stall();
    int first_v;
    first_v = -1;
    push_exp(5'd7, 1'b0); push_exp(5'd8, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_i); #1;
      cfg_en_i = (c < 19); cfg_period_i = 32'd10; cfg_first_i = 5'd7; cfg_num_i = 5'd2;
      core_req_i = (c >= 10 && c <= 13); core_addr_i = 12'hB0A; core_we_i = 1'b0;
      @(negedge clk_i);
      if (core_req_i) begin
        n_cmp++;
        if (hpm_addr_o !== 12'hB0A || core_rdata_o !== exp_bank(5'd10) || busy_o !== 1'b1 || smp_valid_o !== 1'b0) begin
          n_err++; $display("FAIL stall_c%0d: addr=%h rdata=%h busy=%b valid=%b required B0A/%h/1/0",
                            c, hpm_addr_o, core_rdata_o, busy_o, smp_valid_o, exp_bank(5'd10));
        end
      end
      if (smp_valid_o && first_v < 0) first_v = c;
    end
    core_req_i = 1'b0;
    n_cmp++;
    if (first_v != 15 || exp_q.size() != 0) begin
      n_err++; $display("FAIL stall_latency: first valid cycle=%0d pending=%0d required 15/0", first_v, exp_q.size());
    end
  endtask

  // sink stalls for 41 cycles: three ticks land in the busy burst
  task automatic test_backpressure();
    push_exp(5'd3, 1'b0); push_exp(5'd4, 1'b1);
    for (int c = 0; c < 46; c++) begin
      @(posedge clk_i); #1;
      cfg_en_i = (c < 45); cfg_period_i = 32'd10; cfg_first_i = 5'd3; cfg_num_i = 5'd2;
      smp_ready_i = (c >= 41);
      @(negedge clk_i);
      if (c >= 11 && c <= 40) begin
        n_cmp++;
        if (smp_valid_o !== 1'b1 || smp_idx_o !== 5'd3 || smp_data_o !== exp_bank(5'd3)) begin
          n_err++; $display("FAIL bp_hold_c%0d: valid=%b idx=%0d data=%h required 1/3/%h", c, smp_valid_o, smp_idx_o, smp_data_o, exp_bank(5'd3));
        end
      end
    end
    exp_drop = exp_drop + 16'd3;
    n_cmp++;
    if (drop_cnt_o !== exp_drop || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_drop: drop=%0d pending=%0d required %0d/0", drop_cnt_o, exp_q.size(), exp_drop);
    end
  endtask

  // window clipped at 31; then an empty window never starts a burst
  task automatic test_window_clip();
    int busy_seen;
    busy_seen = 0;
    push_exp(5'd30, 1'b0); push_exp(5'd31, 1'b1);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk_i); #1;
      cfg_en_i = (c < 15); cfg_period_i = 32'd10; cfg_first_i = 5'd30; cfg_num_i = 5'd5; smp_ready_i = 1'b1;
      @(negedge clk_i);
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL clip: pending=%0d busy=%b required 0/0", exp_q.size(), busy_o);
    end
    for (int c = 0; c < 16; c++) begin
      @(posedge clk_i); #1;
      cfg_en_i = (c < 15); cfg_period_i = 32'd5; cfg_first_i = 5'd3; cfg_num_i = 5'd0;
      @(negedge clk_i);
      if (busy_o) busy_seen++;
    end
    n_cmp++;
    if (busy_seen != 0 || drop_cnt_o !== exp_drop) begin
      n_err++; $display("FAIL num_zero: busy cycles=%0d drop=%0d required 0/%0d", busy_seen, drop_cnt_o, exp_drop);
    end
  endtask

  // enable falls while a sample is waiting: it still completes, nothing follows
  task automatic test_disable_in_send();
    int late_valid;
    late_valid = 0;
    push_exp(5'd3, 1'b0);
    for (int c = 0; c < 31; c++) begin
      @(posedge clk_i); #1;
      cfg_en_i = (c < 12); cfg_period_i = 32'd10; cfg_first_i = 5'd3; cfg_num_i = 5'd3;
      smp_ready_i = (c >= 14);
      @(negedge clk_i);
      if (c == 13) begin
        n_cmp++;
        if (smp_valid_o !== 1'b1) begin
          n_err++; $display("FAIL dis_hold: valid=%b required 1", smp_valid_o);
        end
      end
      if (c == 15) begin
        n_cmp++;
        if (busy_o !== 1'b0) begin
          n_err++; $display("FAIL dis_idle: busy=%b required 0", busy_o);
        end
      end
      if (c >= 15 && smp_valid_o) late_valid++;
    end
    n_cmp++;
    if (late_valid != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL dis_after: valid cycles=%0d pending=%0d required 0/0", late_valid, exp_q.size());
    end
  endtask

  // reset mid-burst clears everything without waiting for a clock
  task automatic test_reset_mid_burst();
    for (int c = 0; c < 13; c++) begin
      @(posedge clk_i); #1;
      cfg_en_i = 1'b1; cfg_period_i = 32'd10; cfg_first_i = 5'd3; cfg_num_i = 5'd3; smp_ready_i = 1'b0;
      @(negedge clk_i);
    end
    n_cmp++;
    if (smp_valid_o !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: valid=%b required 1", smp_valid_o);
    end
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    #1;
    exp_drop = '0;
    n_cmp++;
    if ({smp_valid_o, busy_o, smp_idx_o, smp_last_o, smp_data_o, drop_cnt_o, state_o, hpm_addr_o} !== '0) begin
      n_err++; $display("FAIL rst_mid: valid=%b busy=%b idx=%0d data=%h drop=%0d state=%0d addr=%h required all 0",
                        smp_valid_o, busy_o, smp_idx_o, smp_data_o, drop_cnt_o, state_o, hpm_addr_o);
    end
    cfg_en_i = 1'b0;
    idle_cycles(2);
    rstn_i = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_core_access();
    idle_cycles(2);
    test_bursts();
    idle_cycles(2);
    test_core_stall();
    idle_cycles(2);
    test_backpressure();
    idle_cycles(2);
    test_window_clip();
    idle_cycles(2);
    test_disable_in_send();
    idle_cycles(2);
    test_reset_mid_burst();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL queue_empty: pending=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
